// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer slave: register offsets, CTRL layout
// and the APB handshake state encoding.
package apb_timer_pkg;

  localparam logic [3:0] CTRL_OFFS  = 4'h0;
  localparam logic [3:0] COUNT_OFFS = 4'h4;
  localparam logic [3:0] CMP_OFFS   = 4'h8;
  localparam logic [3:0] STAT_OFFS  = 4'hC;

  typedef struct packed {
    logic [7:0] presc;
    logic       irq_en;
    logic       auto_reload;
    logic       en;
  } ctrl_reg_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/apb_timer_core.sv
// Prescaler, 32-bit up-counter and compare logic. A software write to COUNT
// takes priority over the tick increment in the same cycle.
module apb_timer_core
  import apb_timer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  ctrl_reg_t   ctrl_i,
  input  logic        ctrl_we_i,
  input  logic        count_we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] compare_i,
  output logic [31:0] count_o,
  output logic        match_set_o
);

  logic [7:0]  psc_q, psc_d;
  logic [31:0] count_q, count_d;
  logic        tick;
  logic        hit;

  always_comb begin
    tick        = ctrl_i.en && (psc_q == ctrl_i.presc);
    hit         = (count_q == compare_i);
    match_set_o = tick && hit;

    // Any CTRL write restarts the prescale period so a new presc takes effect cleanly.
    psc_d = psc_q;
    if (ctrl_we_i) begin
      psc_d = '0;
    end else if (ctrl_i.en) begin
      psc_d = tick ? '0 : psc_q + 8'd1;
    end

    count_d = count_q;
    if (count_we_i) begin
      count_d = wdata_i;
    end else if (tick) begin
      count_d = (hit && ctrl_i.auto_reload) ? '0 : count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      psc_q   <= '0;
      count_q <= '0;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/apb_timer_slv.sv
// APB3 timer slave: two-state handshake FSM with one fixed wait state, the
// register file (CTRL/COMPARE/STAT) and the registered interrupt level.
module apb_timer_slv
  import apb_timer_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter logic [31:0] RESET_COMPARE  = 32'hFFFF_FFFF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      irq_o
);

  if (APB_DATA_WIDTH != 32) begin : g_width_check
    $error("apb_timer_slv: APB_DATA_WIDTH must be 32");
  end

  fsm_state_e  state_q;
  logic [31:0] prdata_q;
  logic        pready_q, pslverr_q;

  ctrl_reg_t   ctrl_q, ctrl_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic        irq_q;

  logic [3:0]  offs;
  logic        addr_err;
  logic        wr_ok;
  logic        ctrl_we, count_we, cmp_we, stat_we;
  logic [31:0] rdata_mux;
  logic [31:0] count;
  logic        match_set;

  always_comb begin
    offs     = paddr_i[3:0];
    addr_err = (paddr_i[1:0] != 2'b00) || (paddr_i[APB_ADDR_WIDTH-1:4] != '0);
    wr_ok    = (state_q == IDLE) && psel_i && penable_i && pwrite_i && !addr_err;
    ctrl_we  = wr_ok && (offs == CTRL_OFFS);
    count_we = wr_ok && (offs == COUNT_OFFS);
    cmp_we   = wr_ok && (offs == CMP_OFFS);
    stat_we  = wr_ok && (offs == STAT_OFFS);

    rdata_mux = '0;
    case (offs)
      CTRL_OFFS:  rdata_mux = {16'h0000, ctrl_q.presc, 5'b00000,
                               ctrl_q.irq_en, ctrl_q.auto_reload, ctrl_q.en};
      COUNT_OFFS: rdata_mux = count;
      CMP_OFFS:   rdata_mux = compare_q;
      STAT_OFFS:  rdata_mux = {31'h0, match_q};
      default:    rdata_mux = '0;
    endcase

    ctrl_d = ctrl_q;
    if (ctrl_we) begin
      ctrl_d.presc       = pwdata_i[15:8];
      ctrl_d.irq_en      = pwdata_i[2];
      ctrl_d.auto_reload = pwdata_i[1];
      ctrl_d.en          = pwdata_i[0];
    end

    compare_d = cmp_we ? pwdata_i : compare_q;

    // Hardware set wins over a coincident write-1-to-clear.
    match_d = match_q;
    if (match_set) begin
      match_d = 1'b1;
    end else if (stat_we && pwdata_i[0]) begin
      match_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psel_i && penable_i) begin
            state_q   <= RESP;
            pready_q  <= 1'b1;
            pslverr_q <= addr_err;
            prdata_q  <= (pwrite_i || addr_err) ? '0 : rdata_mux;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      compare_q <= RESET_COMPARE;
      match_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      irq_q     <= match_q && ctrl_q.irq_en;
    end
  end

  apb_timer_core u_core (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ctrl_i      (ctrl_q),
    .ctrl_we_i   (ctrl_we),
    .count_we_i  (count_we),
    .wdata_i     (pwdata_i),
    .compare_i   (compare_q),
    .count_o     (count),
    .match_set_o (match_set)
  );

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_apb_timer_slv.sv
// Directed bench for apb_timer_slv: a register-access vector table plus
// cycle-aligned sequences for timer ticks, collisions and mid-transfer reset.
module tb_apb_timer_slv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr, irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  apb_timer_slv #(
    .APB_ADDR_WIDTH (12),
    .APB_DATA_WIDTH (32),
    .RESET_COMPARE  (32'hFFFF_FFFF)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .paddr_i   (paddr),
    .pwdata_i  (pwdata),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr),
    .irq_o     (irq)
  );

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is positioned just after a negedge; returns just after the
  // negedge following the ready cycle.
  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk);
    check("pready_access_cycle", {31'b0, pready}, 32'd0);
    penable = 1'b1;
    @(negedge clk);
    check("pready_third_cycle", {31'b0, pready}, 32'd1);
    rdata = prdata;
    err   = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("pready_after_resp", {31'b0, pready}, 32'd0);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] rd_v;
    logic        err_v;
    apb(1'b1, addr, data, rd_v, err_v);
    check("write_pslverr", {31'b0, err_v}, 32'd0);
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] rd_v;
    logic        err_v;
    apb(1'b0, addr, 32'h0, rd_v, err_v);
    check(name, rd_v, exp);
    check({name, "_pslverr"}, {31'b0, err_v}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_v;
    logic        err_v;

    vecs.push_back('{1'b0, 12'h000, 32'h0,         32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 12'h004, 32'h0,         32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 12'h008, 32'h0,         32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{1'b0, 12'h00C, 32'h0,         32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 12'h008, 32'h0000_0010, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 12'h008, 32'h0,         32'h0000_0010, 1'b0});
    vecs.push_back('{1'b0, 12'h010, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 12'h006, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 12'h018, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 12'h009, 32'h1234_5678, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 12'h008, 32'h0,         32'h0000_0010, 1'b0});
    vecs.push_back('{1'b1, 12'h000, 32'hFFFF_FF06, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 12'h000, 32'h0,         32'h0000_FF06, 1'b0});
    vecs.push_back('{1'b1, 12'h00C, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 12'h00C, 32'h0,         32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 12'h004, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 12'h004, 32'h0,         32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{1'b1, 12'h000, 32'h0000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 12'h004, 32'h0,         32'hA5A5_A5A5, 1'b0});

    do_reset();
    check("reset_prdata",  prdata, 32'd0);
    check("reset_pready",  {31'b0, pready}, 32'd0);
    check("reset_pslverr", {31'b0, pslverr}, 32'd0);
    check("reset_irq",     {31'b0, irq}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd_v, err_v);
      check($sformatf("vec%0d_prdata", i), rd_v, vecs[i].exp_rdata);
      check($sformatf("vec%0d_pslverr", i), {31'b0, err_v}, {31'b0, vecs[i].exp_err});
    end

    // Setup phase held without penable must not complete or write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("setup_only_pready", {31'b0, pready}, 32'd0);
    end
    psel = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    rd(12'h008, 32'h0000_0010, "setup_only_no_write");

    // presc=3, auto_reload, irq_en, COMPARE=2: COUNT 0,1,2,0 every 4 cycles.
    do_reset();
    wr(12'h008, 32'd2);
    wr(12'h000, 32'h0000_0307);
    rd(12'h004, 32'd0, "cnt_step0");
    rd(12'h004, 32'd1, "cnt_step1");
    rd(12'h004, 32'd2, "cnt_step2");
    idle(1);
    check("irq_before_match", {31'b0, irq}, 32'd0);
    idle(1);
    check("irq_match_edge", {31'b0, irq}, 32'd0);
    idle(1);
    check("irq_rise", {31'b0, irq}, 32'd1);
    rd(12'h004, 32'd0, "cnt_auto_reload");
    rd(12'h00C, 32'd1, "stat_match_set");
    wr(12'h00C, 32'd1);
    check("irq_after_w1c", {31'b0, irq}, 32'd0);
    rd(12'h00C, 32'd0, "stat_after_w1c");

    // COUNT write on a tick edge, then STAT W1C on a match edge.
    do_reset();
    wr(12'h008, 32'h0000_0101);
    wr(12'h000, 32'h0000_0301);
    idle(1);
    wr(12'h004, 32'h0000_0100);
    rd(12'h004, 32'h0000_0100, "count_write_beats_tick");
    idle(2);
    wr(12'h00C, 32'd1);
    rd(12'h00C, 32'd1, "match_beats_w1c");
    check("irq_disabled", {31'b0, irq}, 32'd0);

    // Wrap from all-ones without a spurious match.
    do_reset();
    wr(12'h008, 32'd5);
    wr(12'h004, 32'hFFFF_FFFF);
    wr(12'h000, 32'h0000_0301);
    idle(3);
    rd(12'h004, 32'd0, "count_wrap");
    rd(12'h00C, 32'd0, "no_match_on_wrap");

    // Reset asserted during the ready cycle of a COMPARE write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h55;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check("midreset_in_resp", {31'b0, pready}, 32'd1);
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    check("midreset_pready", {31'b0, pready}, 32'd0);
    check("midreset_prdata", prdata, 32'd0);
    rst_n = 1'b1;
    rd(12'h008, 32'hFFFF_FFFF, "midreset_compare");
    wr(12'h008, 32'd7);
    rd(12'h008, 32'd7, "post_reset_xfer");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
